// File: rtl/tx_word_serializer_pkg.sv
// Shared constants for the word-to-byte transmit serializer.
// Holds state encodings and byte-counter sizing helpers.
package tx_word_serializer_pkg;

  localparam int WORD_W_DFLT    = 128;
  localparam int BYTE_W_DFLT    = 8;
  localparam int DEPTH_DFLT     = 2;
  localparam int BYTES_PER_WORD = WORD_W_DFLT / BYTE_W_DFLT;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // A single-byte word still needs a one-bit counter.
  function automatic int bcnt_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/tx_word_serializer_fifo.sv
// DEPTH x W synchronous FIFO with async reset.
// A write into a full FIFO is accepted when a pop happens on the same edge.
module word_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_word_serializer.sv
// Buffers result words and streams them MSB byte first
// over a valid/ready byte handshake to the UART transmitter.
module tx_word_serializer
  import tx_word_serializer_pkg::*;
#(
  parameter int WORD_W = WORD_W_DFLT,
  parameter int BYTE_W = BYTE_W_DFLT,
  parameter int DEPTH  = DEPTH_DFLT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              word_done,
  output logic              busy,
  output logic              overflow
);

  localparam int BPW   = WORD_W / BYTE_W;
  localparam int CNT_W = bcnt_width(BPW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

  logic [0:0]             state;
  logic [WORD_W-1:0]      shreg;
  logic [CNT_W-1:0]       bcnt;
  logic [WORD_W-1:0]      fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   hs;
  logic                   last;
  logic                   pop;

  word_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign byte_valid = (state == ST_SEND);
  assign byte_out   = shreg[WORD_W-1 -: BYTE_W];
  assign busy       = (fifo_count != '0) || (state == ST_SEND);

  assign hs   = byte_valid && byte_ready;
  assign last = (bcnt == LAST);

  // Reload straight from the FIFO on the final handshake so words chain
  // without a bubble.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || (hs && last));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      word_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (tx_wr && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg <= fifo_rdata;
            bcnt  <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (hs) begin
            if (!last) begin
              shreg <= shreg << BYTE_W;
              bcnt  <= bcnt + 1'b1;
            end else begin
              word_done <= 1'b1;
              bcnt      <= '0;
              if (!fifo_empty) begin
                shreg <= fifo_rdata;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_word_serializer.sv
// Directed bench for tx_word_serializer: latency, ordering,
// backpressure, chaining, overflow, full+pop and async reset.
module tb_tx_word_serializer;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] tx_data;
  logic         tx_wr;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         word_done;
  logic         busy;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         hold_err = 0;
  logic       hold_chk = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;

  tx_word_serializer dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .word_done  (word_done),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #10 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      if (byte_valid && byte_ready) begin
        got_q.push_back(byte_out);
        got_cyc.push_back(cyc);
      end
      if (word_done) done_cnt++;
      if (hold_chk && prev_stall && byte_out != prev_byte) hold_err++;
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write_word(input logic [127:0] w);
    tx_data = w;
    tx_wr   = 1'b1;
    tick();
    tx_wr   = 1'b0;
    tx_data = '0;
  endtask

  task automatic clear_rec();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic push_exp(input logic [127:0] w);
    for (int i = 0; i < 16; i++) exp_q.push_back(w[127-8*i -: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    chk({tag, " idle"}, busy, 0);
    tick(2);
  endtask

  task automatic cmp_stream(input string tag);
    int errs;
    int n;
    errs = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    chk({tag, " len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) errs++;
    chk({tag, " bytes"}, errs, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] w;
    int k;
    reset      = 1'b1;
    tx_wr      = 1'b0;
    tx_data    = '0;
    byte_ready = 1'b1;
    tick(2);
    chk("rst valid", byte_valid, 0);
    chk("rst byte", byte_out, 0);
    chk("rst done", word_done, 0);
    chk("rst busy", busy, 0);
    chk("rst ovf", overflow, 0);
    reset = 1'b0;
    tick();

    // 1: single word, ready tied high
    clear_rec();
    w = 128'h000102030405060708090A0B0C0D0E0F;
    push_exp(w);
    write_word(w);
    chk("t1 lat0", byte_valid, 0);
    tick();
    chk("t1 lat1", byte_valid, 1);
    chk("t1 b0", byte_out, 8'h00);
    wait_idle("t1");
    cmp_stream("t1");
    chk("t1 span", got_cyc[got_cyc.size()-1] - got_cyc[0], 15);
    chk("t1 done", done_cnt, 1);
    chk("t1 busy", busy, 0);

    // 2: backpressure pattern 1,0,0
    clear_rec();
    hold_err = 0;
    hold_chk = 1'b1;
    push_exp(w);
    write_word(w);
    k = 0;
    while (busy && k < 400) begin
      byte_ready = (k % 3 == 0);
      tick();
      k++;
    end
    chk("t2 idle", busy, 0);
    byte_ready = 1'b1;
    tick(2);
    hold_chk = 1'b0;
    cmp_stream("t2");
    chk("t2 hold", hold_err, 0);
    chk("t2 done", done_cnt, 1);

    // 3: back-to-back words, no bubble between them
    clear_rec();
    push_exp({16{8'hAA}});
    push_exp({16{8'h55}});
    write_word({16{8'hAA}});
    write_word({16{8'h55}});
    wait_idle("t3");
    cmp_stream("t3");
    chk("t3 span", got_cyc[got_cyc.size()-1] - got_cyc[0], 31);
    chk("t3 done", done_cnt, 2);
    chk("t3 ovf", overflow, 0);

    // 4: overflow; one word sits in the shifter, two in the FIFO
    clear_rec();
    byte_ready = 1'b0;
    push_exp(128'h1);
    push_exp(128'h2);
    push_exp(128'h3);
    write_word(128'h1);
    write_word(128'h2);
    write_word(128'h3);
    chk("t4 ovf3", overflow, 0);
    write_word(128'h4);
    chk("t4 ovf4", overflow, 1);
    byte_ready = 1'b1;
    wait_idle("t4");
    cmp_stream("t4");
    chk("t4 done", done_cnt, 3);
    chk("t4 sticky", overflow, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t5 ovf clr", overflow, 0);

    // 5: full FIFO, write lands on the final-handshake pop edge
    clear_rec();
    byte_ready = 1'b0;
    push_exp(128'h11);
    push_exp(128'h22);
    push_exp(128'h33);
    push_exp(128'h44);
    write_word(128'h11);
    write_word(128'h22);
    write_word(128'h33);
    tick(2);
    byte_ready = 1'b1;
    tick(15);
    write_word(128'h44);
    chk("t5 ovf", overflow, 0);
    wait_idle("t5");
    cmp_stream("t5");
    chk("t5 done", done_cnt, 4);
    chk("t5 ovf end", overflow, 0);

    // 6: async reset mid-word
    clear_rec();
    write_word(128'h0123456789ABCDEF0123456789ABCDEF);
    k = 0;
    while (got_q.size() < 6 && k < 100) begin
      tick();
      k++;
    end
    chk("t6 six", got_q.size(), 6);
    reset = 1'b1;
    #1;
    chk("t6 async", byte_valid, 0);
    chk("t6 busy rst", busy, 0);
    tick(3);
    reset = 1'b0;
    tick(5);
    chk("t6 valid", byte_valid, 0);
    chk("t6 busy", busy, 0);
    chk("t6 ovf", overflow, 0);
    chk("t6 count", got_q.size(), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
